// File: rtl/serv_trace_buf.sv
// Instruction-retirement trace buffer for SERV: deserialises rd write-back, latches the
// fetched instruction and queues one record per retirement in a show-ahead FIFO.
module serv_trace_buf #(
  parameter int unsigned W        = 1,
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [31:0]             i_ibus_rdt,
  input  logic                    i_ibus_ack,
  input  logic [31:0]             i_ibus_adr,
  input  logic                    i_wen0,
  input  logic [W-1:0]            i_wdata0,
  input  logic [4:0]              i_rd_addr,
  input  logic                    i_cnt_done,
  input  logic                    i_ctrl_pc_en,
  input  logic                    i_trap,
  input  logic                    i_flush,
  output logic                    o_tr_valid,
  input  logic                    i_tr_ready,
  output logic [31:0]             o_tr_pc,
  output logic [31:0]             o_tr_insn,
  output logic [4:0]              o_tr_rd_addr,
  output logic [31:0]             o_tr_rd_wdata,
  output logic                    o_tr_trap,
  output logic [31:0]             o_tr_order,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic                    o_ovf,
  output logic [7:0]              o_drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        trap;
    logic [31:0] order;
  } rec_t;

  logic [31:0]   sr_q, sr_d;
  logic [31:0]   insn_q, insn_d;
  logic          wr_seen_q, wr_seen_d;
  logic          trap_q, trap_d;
  logic          ret_q, ret_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   order_q, order_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  rec_t          mem_q [DEPTH];
  rec_t          push_rec;
  rec_t          head;
  logic [W+31:0] sr_cat;
  logic [4:0]    rd_eff;
  logic          valid, pop, push, full, accept, drop, mem_we;

  always_comb begin
    sr_cat    = {i_wdata0, sr_q} >> W;
    sr_d      = i_wen0 ? sr_cat[31:0] : sr_q;
    insn_d    = i_ibus_ack ? i_ibus_rdt : insn_q;
    // The push cycle closes the instruction; activity in it belongs to the next one.
    wr_seen_d = (wr_seen_q & ~ret_q) | i_wen0;
    trap_d    = (trap_q & ~ret_q) | i_trap;
    ret_d     = i_cnt_done & i_ctrl_pc_en;

    rd_eff            = (wr_seen_q && (i_rd_addr != 5'd0)) ? i_rd_addr : 5'd0;
    push_rec.pc       = pc_q;
    push_rec.insn     = insn_q;
    push_rec.rd_addr  = rd_eff;
    push_rec.rd_wdata = (rd_eff != 5'd0) ? sr_q : 32'd0;
    push_rec.trap     = trap_q;
    push_rec.order    = order_q;

    valid  = (level_q != '0);
    pop    = valid & i_tr_ready;
    push   = ret_q;
    full   = (level_q == LW'(DEPTH));
    accept = push & (~full | pop);
    drop   = push & ~accept;
    mem_we = accept & ~i_flush;

    // pc/order advance on every retirement so gaps in order expose drops.
    pc_d    = push ? i_ibus_adr : pc_q;
    order_d = push ? order_q + 32'd1 : order_q;

    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (i_flush) begin
      wptr_d     = '0;
      rptr_d     = '0;
      level_d    = '0;
      ovf_d      = 1'b0;
      drop_cnt_d = 8'd0;
    end else begin
      if (accept) wptr_d = wptr_q + AW'(1);
      if (pop)    rptr_d = rptr_q + AW'(1);
      if (accept && !pop)      level_d = level_q + LW'(1);
      else if (!accept && pop) level_d = level_q - LW'(1);
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_cnt_q != 8'hff) drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sr_q       <= '0;
      insn_q     <= '0;
      wr_seen_q  <= 1'b0;
      trap_q     <= 1'b0;
      ret_q      <= 1'b0;
      pc_q       <= RESET_PC;
      order_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      sr_q       <= sr_d;
      insn_q     <= insn_d;
      wr_seen_q  <= wr_seen_d;
      trap_q     <= trap_d;
      ret_q      <= ret_d;
      pc_q       <= pc_d;
      order_q    <= order_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem_q[wptr_q] <= push_rec;
  end

  always_comb begin
    head          = mem_q[rptr_q];
    o_tr_valid    = valid;
    o_tr_pc       = valid ? head.pc : 32'd0;
    o_tr_insn     = valid ? head.insn : 32'd0;
    o_tr_rd_addr  = valid ? head.rd_addr : 5'd0;
    o_tr_rd_wdata = valid ? head.rd_wdata : 32'd0;
    o_tr_trap     = valid & head.trap;
    o_tr_order    = valid ? head.order : 32'd0;
    o_level       = level_q;
    o_ovf         = ovf_q;
    o_drop_cnt    = drop_cnt_q;
  end

endmodule

// File: tb/tb_serv_trace_buf.sv
// Directed table-driven bench for serv_trace_buf (W=4, DEPTH=4): capture, drop accounting,
// full push+pop, flush and mid-instruction async reset.
module tb_serv_trace_buf;

  localparam int unsigned W        = 4;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ibus_rdt, ibus_adr;
  logic        ibus_ack, wen0, cnt_done, pc_en, trap, flush, ready;
  logic [W-1:0] wdata0;
  logic [4:0]  rd_addr;
  logic        tr_valid, tr_trap, ovf;
  logic [31:0] tr_pc, tr_insn, tr_wd, tr_order;
  logic [4:0]  tr_rd;
  logic [2:0]  level;
  logic [7:0]  drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] insn;
    logic [4:0]  rd;
    logic [31:0] val;
    bit          wen;
    bit          trap;
    logic [31:0] npc;
    logic [31:0] e_pc;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    logic [31:0] e_order;
  } vec_t;

  vec_t tab [17];

  always #5 clk = ~clk;

  serv_trace_buf #(.W(W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_ibus_rdt    (ibus_rdt),
    .i_ibus_ack    (ibus_ack),
    .i_ibus_adr    (ibus_adr),
    .i_wen0        (wen0),
    .i_wdata0      (wdata0),
    .i_rd_addr     (rd_addr),
    .i_cnt_done    (cnt_done),
    .i_ctrl_pc_en  (pc_en),
    .i_trap        (trap),
    .i_flush       (flush),
    .o_tr_valid    (tr_valid),
    .i_tr_ready    (ready),
    .o_tr_pc       (tr_pc),
    .o_tr_insn     (tr_insn),
    .o_tr_rd_addr  (tr_rd),
    .o_tr_rd_wdata (tr_wd),
    .o_tr_trap     (tr_trap),
    .o_tr_order    (tr_order),
    .o_level       (level),
    .o_ovf         (ovf),
    .o_drop_cnt    (drop_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, 32'(tr_valid), 32'd0);
    chk({tag, ".level"}, 32'(level), 32'd0);
    chk({tag, ".ovf"}, 32'(ovf), 32'd0);
    chk({tag, ".drop"}, 32'(drop_cnt), 32'd0);
    chk({tag, ".pc"}, tr_pc, 32'd0);
    chk({tag, ".insn"}, tr_insn, 32'd0);
    chk({tag, ".rd"}, 32'(tr_rd), 32'd0);
    chk({tag, ".wd"}, tr_wd, 32'd0);
    chk({tag, ".trap"}, 32'(tr_trap), 32'd0);
    chk({tag, ".order"}, tr_order, 32'd0);
  endtask

  task automatic check_rec(input int i);
    vec_t v = tab[i];
    chk($sformatf("valid[%0d]", i), 32'(tr_valid), 32'd1);
    chk($sformatf("pc[%0d]", i), tr_pc, v.e_pc);
    chk($sformatf("insn[%0d]", i), tr_insn, v.insn);
    chk($sformatf("rd[%0d]", i), 32'(tr_rd), 32'(v.e_rd));
    chk($sformatf("wd[%0d]", i), tr_wd, v.e_wd);
    chk($sformatf("trap[%0d]", i), 32'(tr_trap), 32'(v.trap));
    chk($sformatf("order[%0d]", i), tr_order, v.e_order);
  endtask

  // Returns at the negedge inside the push cycle (one cycle after retirement).
  task automatic run_insn(input int i);
    vec_t v = tab[i];
    @(negedge clk);
    ibus_ack = 1'b1; ibus_rdt = v.insn; rd_addr = v.rd;
    @(negedge clk);
    ibus_ack = 1'b0; ibus_rdt = 32'd0;
    for (int k = 0; k < 32 / W; k++) begin
      wen0 = v.wen; wdata0 = v.val[k*W +: W]; trap = v.trap && (k == 0);
      @(negedge clk);
    end
    wen0 = 1'b0; wdata0 = '0; trap = 1'b0;
    cnt_done = 1'b1; pc_en = 1'b1; ibus_adr = v.npc;
    @(negedge clk);
    cnt_done = 1'b0; pc_en = 1'b0;
  endtask

  task automatic pop_one();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  initial begin
    //         insn          rd     val           wen   trap  npc            e_pc           e_rd   e_wd          e_order
    tab[0]  = '{32'h12300293, 5'd5,  32'h00000123, 1'b1, 1'b0, 32'h80000004, 32'h80000000, 5'd5,  32'h00000123, 32'd0};
    tab[1]  = '{32'h0052a023, 5'd7,  32'h00000000, 1'b0, 1'b0, 32'h80000008, 32'h80000004, 5'd0,  32'h00000000, 32'd1};
    tab[2]  = '{32'h00100013, 5'd0,  32'h00000001, 1'b1, 1'b0, 32'h8000000c, 32'h80000008, 5'd0,  32'h00000000, 32'd2};
    tab[3]  = '{32'h00000073, 5'd0,  32'h00000000, 1'b0, 1'b1, 32'h80000100, 32'h8000000c, 5'd0,  32'h00000000, 32'd3};
    tab[4]  = '{32'h00a00313, 5'd6,  32'h0000000a, 1'b1, 1'b0, 32'h80000104, 32'h80000100, 5'd6,  32'h0000000a, 32'd4};
    tab[5]  = '{32'h00b00393, 5'd7,  32'h0000000b, 1'b1, 1'b0, 32'h80000108, 32'h80000104, 5'd7,  32'h0000000b, 32'd5};
    tab[6]  = '{32'h00600413, 5'd8,  32'hdeadbeef, 1'b1, 1'b0, 32'h8000010c, 32'h80000108, 5'd8,  32'hdeadbeef, 32'd6};
    tab[7]  = '{32'h00700493, 5'd9,  32'ha5a5a5a5, 1'b1, 1'b0, 32'h80000110, 32'h8000010c, 5'd9,  32'ha5a5a5a5, 32'd7};
    tab[8]  = '{32'h00800513, 5'd10, 32'h12345678, 1'b1, 1'b1, 32'h80000114, 32'h80000110, 5'd10, 32'h12345678, 32'd8};
    tab[9]  = '{32'h00900593, 5'd11, 32'hffffffff, 1'b1, 1'b0, 32'h80000118, 32'h80000114, 5'd11, 32'hffffffff, 32'd9};
    tab[10] = '{32'h00a00613, 5'd12, 32'h0f0f0f0f, 1'b1, 1'b0, 32'h8000011c, 32'h80000118, 5'd12, 32'h0f0f0f0f, 32'd10};
    tab[11] = '{32'h00b00693, 5'd13, 32'h11111111, 1'b1, 1'b0, 32'h80000120, 32'h8000011c, 5'd13, 32'h11111111, 32'd11};
    tab[12] = '{32'h00c00713, 5'd14, 32'h22222222, 1'b1, 1'b0, 32'h80000124, 32'h80000120, 5'd14, 32'h22222222, 32'd12};
    tab[13] = '{32'h00d00793, 5'd15, 32'h33333333, 1'b1, 1'b0, 32'h80000128, 32'h80000124, 5'd15, 32'h33333333, 32'd13};
    tab[14] = '{32'h00e00813, 5'd16, 32'h44444444, 1'b1, 1'b0, 32'h8000012c, 32'h80000128, 5'd16, 32'h44444444, 32'd14};
    tab[15] = '{32'h00f00893, 5'd17, 32'h55555555, 1'b1, 1'b0, 32'h80000130, 32'h8000012c, 5'd17, 32'h55555555, 32'd15};
    tab[16] = '{32'h0052a023, 5'd9,  32'h00000000, 1'b0, 1'b0, 32'h80000004, 32'h80000000, 5'd0,  32'h00000000, 32'd0};

    rst_n = 1'b0; ibus_rdt = '0; ibus_adr = '0; ibus_ack = 1'b0; wen0 = 1'b0; wdata0 = '0;
    rd_addr = '0; cnt_done = 1'b0; pc_en = 1'b0; trap = 1'b0; flush = 1'b0; ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // Capture and N+2 latency.
    run_insn(0);
    chk("valid_push_cycle", 32'(tr_valid), 32'd0);
    @(negedge clk);
    check_rec(0);
    chk("level_1", 32'(level), 32'd1);

    // Overflow: no-write, x0 write, trap, then two drops.
    for (int i = 1; i <= 5; i++) run_insn(i);
    @(negedge clk);
    chk("ovf_level", 32'(level), 32'd4);
    chk("ovf_flag", 32'(ovf), 32'd1);
    chk("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
    for (int i = 0; i <= 3; i++) begin
      check_rec(i);
      pop_one();
    end
    chk("drained_valid", 32'(tr_valid), 32'd0);
    chk("drained_level", 32'(level), 32'd0);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    run_insn(6);
    @(negedge clk);
    check_rec(6);

    // Full FIFO with a push coinciding with a pop.
    for (int i = 7; i <= 9; i++) run_insn(i);
    @(negedge clk);
    chk("full_level", 32'(level), 32'd4);
    run_insn(10);
    pop_one();
    chk("fullpp_level", 32'(level), 32'd4);
    chk("fullpp_drop", 32'(drop_cnt), 32'd2);
    for (int i = 7; i <= 10; i++) begin
      check_rec(i);
      pop_one();
    end
    chk("fullpp_empty", 32'(tr_valid), 32'd0);

    // Flush in a push cycle.
    for (int i = 11; i <= 13; i++) run_insn(i);
    @(negedge clk);
    chk("preflush_level", 32'(level), 32'd3);
    run_insn(14);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_ovf", 32'(ovf), 32'd0);
    chk("flush_drop", 32'(drop_cnt), 32'd0);
    chk("flush_valid", 32'(tr_valid), 32'd0);
    @(negedge clk);
    chk("flush_level_after", 32'(level), 32'd0);
    run_insn(15);
    @(negedge clk);
    check_rec(15);

    // Async reset halfway through a write-back, with a record still queued.
    @(negedge clk);
    ibus_ack = 1'b1; ibus_rdt = 32'h00300193; rd_addr = 5'd3;
    @(negedge clk);
    ibus_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wen0 = 1'b1; wdata0 = 4'hf;
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1 chk_zero("midreset");
    wen0 = 1'b0; wdata0 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_insn(16);
    chk("postreset_push_cycle", 32'(tr_valid), 32'd0);
    @(negedge clk);
    check_rec(16);
    chk("postreset_level", 32'(level), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serv_trace_buf.md
# serv_trace_buf

Parametrised instruction-retirement trace buffer for the SERV core. It deserialises the W-bit-per-cycle register write-back stream and latches the fetched instruction word. On each retirement it pushes a fixed-format record into a DEPTH-entry FIFO, read out over a valid/ready port. It sits beside the core alongside the debug monitor and adds buffering, backpressure, overflow accounting and flush.

## Interface
Parameters:
- W, 1, serial datapath width; one of 1, 2, 4, 8, 16, 32.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- RESET_PC, 0, PC value after reset.

Ports (one clock; reset is asynchronous and active-low):
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_ibus_rdt  in  32  fetched instruction word.
- i_ibus_ack  in  1  instruction fetch acknowledge.
- i_ibus_adr  in  32  next-PC (fetch address).
- i_wen0  in  1  RF write-port-0 enable for this cycle.
- i_wdata0  in  W  RF write data, LSB-first slice.
- i_rd_addr  in  5  destination register of the current instruction.
- i_cnt_done  in  1  last cycle of the current instruction's count.
- i_ctrl_pc_en  in  1  PC-update phase.
- i_trap  in  1  the current instruction traps.
- i_flush  in  1  synchronous FIFO flush and statistics clear.
- o_tr_valid  out  1  head record available.
- i_tr_ready  in  1  consumer accepts the head record.
- o_tr_pc  out  32  PC of the retired instruction.
- o_tr_insn  out  32  instruction word.
- o_tr_rd_addr  out  5  rd index; 0 if there is no RF write or rd = x0.
- o_tr_rd_wdata  out  32  rd value; 0 when o_tr_rd_addr = 0.
- o_tr_trap  out  1  the instruction trapped.
- o_tr_order  out  32  retirement sequence number.
- o_level  out  $clog2(DEPTH)+1  current occupancy.
- o_ovf  out  1  sticky: at least one record dropped.
- o_drop_cnt  out  8  dropped-record count, saturates at 255.

## Operation
- **Deserialiser:** when i_wen0 is high, sr <= {i_wdata0, sr[31:W]}. A per-instruction flag `wr_seen` is set by any i_wen0 and cleared when a record is pushed or dropped.
- **Instruction latch:** insn <= i_ibus_rdt when i_ibus_ack is high. A trap flag is captured as trap_q |= i_trap and cleared with `wr_seen`.
- **Retire:** a retirement occurs in the cycle where i_cnt_done & i_ctrl_pc_en is high. `ret_q` is registered high for exactly the next cycle; that cycle is the push cycle.
- **Push cycle:**
  - The record is {pc, insn, rd_addr', rd_wdata', trap_q, order}.
  - rd_addr' = (wr_seen & |i_rd_addr) ? i_rd_addr : 0.
  - rd_wdata' = rd_addr' ? sr : 0.
  - pc <= i_ibus_adr and order <= order + 1 on every retirement, whether the record is accepted or dropped, so gaps in o_tr_order expose drops.
- **Accept/drop:**
  - A push is accepted if level < DEPTH, or if a pop happens in the same cycle.
  - Otherwise the record is dropped: o_ovf <= 1 and o_drop_cnt increments, saturating at 255.
- **Pop:** occurs when o_tr_valid & i_tr_ready. The FIFO is show-ahead: outputs reflect the head entry.
- **Level:** o_level = level. It rises by 1 on push-only, falls by 1 on pop-only, and is unchanged on push+pop.
- **Pointers:** read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- **Flush:**
  - When i_flush is high, level, both pointers, o_ovf and o_drop_cnt are cleared.
  - Flush has priority over a same-cycle push and pop. A record pushed in the flush cycle is discarded and is not counted as a drop.
  - pc and order are unaffected by flush.
- **Reset:**
  - The FIFO is empty: o_tr_valid = 0, o_level = 0, o_ovf = 0, o_drop_cnt = 0.
  - pc = RESET_PC and order = 0. sr, insn, wr_seen, trap_q and ret_q are 0.
  - All record outputs read 0 while the FIFO is empty.
  - Reset asserted mid-instruction discards the partial instruction; no record is pushed for it.

## Timing
- Retire in cycle N → push in N+1 → o_tr_valid high in N+2 (the FIFO was empty).
- Pop in cycle M → the next entry, or o_tr_valid = 0, appears in M+1.
- Throughput: one push and one pop per cycle.
- While o_tr_valid is high and i_tr_ready is low, all o_tr_* outputs are held stable.
- o_tr_valid never deasserts without a pop, except on flush or reset.
- A full FIFO with a simultaneous push and pop keeps level = DEPTH and drops nothing.

## Test plan
- **Write-back capture, W=1 and W=4:** instruction "addi x5,x0,0x123" with 32/W serial write cycles, then retire → one record: rd_addr 5, rd_wdata 0x00000123, pc RESET_PC, order 0, valid at N+2.
- **No-write and x0 cases:** a store instruction (no i_wen0), then a write to x0 → both records have rd_addr 0 and rd_wdata 0; orders are 0 and 1.
- **Overflow, DEPTH=4:** i_tr_ready = 0, 6 retirements → level 4, o_ovf 1, drop_cnt 2. Draining shows orders 0..3. The next record carries order 6.
- **Full with simultaneous pop:** FIFO full, retirement push coincides with i_tr_ready = 1 → level stays 4, drop_cnt unchanged, the new record is at the tail.
- **Flush with concurrent push:** 3 entries, i_flush asserted in the push cycle → level 0, o_ovf 0. The next retirement is visible with order 4.
- **Async reset mid-instruction:** i_rst_n pulled low halfway through the serial write-back → all outputs 0 immediately. After release the first record has pc RESET_PC and order 0.
